ftsd_scan_sched: RTL and testbench
==================================

Name: ftsd_scan_sched

Overview:
- Scan scheduler for the four-digit seven-segment display.
- Shares the display between two requesters, A (normal data) and B (overlay/message). Each requester offers a 16-bit frame of four BCD nibbles.
- Latches one granted frame per scan frame, then time-multiplexes its digits with a programmable dwell and an anti-ghosting blank gap.
- Replaces the free-running scan divider: digit select, digit enables and BCD code all come from this block.

Parameters:
- DWELL_CYCLES, 4096: clksys cycles each digit is driven; must be ≥1.
- BLANK_CYCLES, 64: clksys cycles of all-digits-off after each digit; 0 is legal and means no gap.

Ports:
- clksys  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- a_req  input  1  requester A wants its frame displayed; held until a_ack.
- a_digits  input  16  A frame; nibble i (bits 4i+3:4i) is shown on digit i.
- a_ack  output  1  one-cycle pulse: A frame latched.
- b_req  input  1  requester B request; same rules as a_req.
- b_digits  input  16  B frame.
- b_ack  output  1  one-cycle pulse: B frame latched.
- ftsd_ctl  output  4  digit enables, active-low one-hot; 4'b1111 means all off.
- ftsd_bcd  output  4  BCD code for the enabled digit; 4'hF during the gap.
- scan_idx  output  2  index of the current digit slot.
- owner  output  1  0 = buffer holds A's frame, 1 = B's frame.
- frame_tick  output  1  one-cycle pulse on the last cycle of each frame.

Behaviour:
- All outputs are registered. Reset values:
  - ftsd_ctl=4'b1110, ftsd_bcd=4'h0, scan_idx=0
  - owner=0, a_ack=0, b_ack=0, frame_tick=0
  - internal frame buffer=16'h0000, last_grant=B, phase=ON, dwell counter=0
- Phase state machine per digit slot:
  - ON lasts DWELL_CYCLES cycles: ftsd_ctl bit scan_idx low, all others high; ftsd_bcd = buffer nibble scan_idx.
  - GAP lasts BLANK_CYCLES cycles: ftsd_ctl=4'b1111, ftsd_bcd=4'hF. GAP is skipped when BLANK_CYCLES=0.
  - At the end of the slot, scan_idx increments, wrapping 3→0, and the phase returns to ON.
- Timing after reset release: cycles 0..DWELL-1 drive digit 0 ON. Frame period = 4*(DWELL_CYCLES+BLANK_CYCLES) cycles.
- frame_tick:
  - Asserted on the final cycle of digit 3's slot: the last GAP cycle, or the last ON cycle when BLANK_CYCLES=0.
  - That cycle is the frame boundary.
- Arbitration, evaluated only at the boundary:
  - Only b_req → grant B.
  - Only a_req → grant A.
  - Both → grant the requester that is not last_grant (round-robin; no starvation).
  - Neither → buffer, owner and last_grant are unchanged.
- Grant actions, on the boundary edge:
  - Buffer loads the winner's digits; owner and last_grant update.
  - The winner's ack is high for exactly the next cycle, i.e. the first ON cycle of digit 0 showing the new frame.
  - The loser's req stays pending and is served at a later boundary.
- Handshake:
  - A requester must hold req and digits stable until its ack.
  - It drops req in the ack cycle, or keeps req high to request another frame at the next boundary.
  - Digits changing while req is pending are sampled at the boundary edge only.
  - req rising between boundaries has no effect until the next boundary.
- a_ack and b_ack are never high in the same cycle.
- Counter width is sized from max(DWELL_CYCLES, BLANK_CYCLES). The counter reloads to 0 on each phase change, with no cumulative drift.
- rst_n asserted at any time, including mid-slot or in the ack cycle: all registers go immediately to their reset values and any pending grant is discarded. Scanning resumes at digit 0 ON on the first edge after release.

Test Plan:
- Use DWELL_CYCLES=4, BLANK_CYCLES=2 (frame period 24) unless stated.
- Idle scan, no requests: ftsd_ctl sequence 1110 ×4, 1111 ×2, 1101 ×4, 1111 ×2, 1011…, 0111…, then repeats. ftsd_bcd=0 during ON. frame_tick high on cycles 23, 47, ….
- a_req=1 with a_digits=16'h4321 from cycle 5:
  - Latched on edge 23; a_ack high on cycle 24 only; owner=0.
  - Next frame shows bcd 1,2,3,4 on digits 0..3.
- a_req and b_req both high from reset, b_digits=16'h9876, a_digits=16'h1111; each requester drops req after its ack and re-raises it 1 cycle later:
  - Grants alternate A (tie, last_grant=B), then B, then A.
  - owner toggles 0,1,0 at cycles 24, 48, 72.
- b_req pulse from cycle 30 to 35 only, dropped before its ack: no grant, buffer unchanged, b_ack never asserted.
- BLANK_CYCLES=0, DWELL_CYCLES=3: period 12, ftsd_ctl never 4'b1111, frame_tick on cycle 11.
- rst_n low at cycle 24, coincident with the a_ack cycle:
  - a_ack drops asynchronously; buffer=0, ftsd_ctl=4'b1110.
  - After release, the timing restarts as in scenario 1.

Source files
------------

// File: rtl/ftsd_scan_sched_if.sv
// Requester handshake bundle for the seven-segment scan scheduler.
// Requester A carries normal data and requester B carries the overlay/message frame.
interface ftsd_scan_sched_if;
  logic        a_req;
  logic [15:0] a_digits;
  logic        a_ack;
  logic        b_req;
  logic [15:0] b_digits;
  logic        b_ack;

  modport master (output a_req, a_digits, b_req, b_digits, input a_ack, b_ack);
  modport slave  (input a_req, a_digits, b_req, b_digits, output a_ack, b_ack);
endinterface

// File: rtl/ftsd_scan_sched.sv
// Four-digit seven-segment scan scheduler: round-robin frame latch between two
// requesters, with per-digit dwell and an anti-ghosting blank gap.
module ftsd_scan_sched #(
  parameter int DWELL_CYCLES = 4096,
  parameter int BLANK_CYCLES = 64
) (
  input  logic               clksys,
  input  logic               rst_n,
  ftsd_scan_sched_if.slave   req_if,
  output logic [3:0]         ftsd_ctl,
  output logic [3:0]         ftsd_bcd,
  output logic [1:0]         scan_idx,
  output logic               owner,
  output logic               frame_tick
);

  localparam int MAXC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam bit HAS_GAP = (BLANK_CYCLES > 0);

  localparam logic [0:0] PH_ON  = 1'b0;
  localparam logic [0:0] PH_GAP = 1'b1;
  localparam logic GR_A = 1'b0;
  localparam logic GR_B = 1'b1;

  logic [0:0]    r_phase;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_idx;
  logic [15:0]   r_buf;
  logic          r_owner;
  logic          r_last;
  logic          r_a_ack;
  logic          r_b_ack;
  logic          r_tick;
  logic [3:0]    r_ctl;
  logic [3:0]    r_bcd;

  logic [0:0]    w_next_phase;
  logic [CW-1:0] w_next_cnt;
  logic [1:0]    w_next_idx;
  logic          w_slot_end;
  logic          w_boundary;
  logic          w_grant_a;
  logic          w_grant_b;
  logic [15:0]   w_next_buf;
  logic          w_next_owner;
  logic          w_next_tick;

  always_comb begin
    w_next_phase = r_phase;
    w_next_cnt   = r_cnt + 1'b1;
    w_next_idx   = r_idx;
    w_slot_end   = 1'b0;
    if (r_phase == PH_ON) begin
      if (r_cnt == DWELL_LAST) begin
        w_next_cnt = '0;
        if (HAS_GAP) begin
          w_next_phase = PH_GAP;
        end else begin
          w_slot_end = 1'b1;
          w_next_idx = r_idx + 2'd1;
        end
      end
    end else if (r_cnt == BLANK_LAST) begin
      w_next_cnt   = '0;
      w_next_phase = PH_ON;
      w_slot_end   = 1'b1;
      w_next_idx   = r_idx + 2'd1;
    end
  end

  // Arbitration only at the frame boundary; a tie goes to whoever was not served last.
  assign w_boundary = w_slot_end && (r_idx == 2'd3);
  assign w_grant_a  = w_boundary && req_if.a_req && (!req_if.b_req || r_last == GR_B);
  assign w_grant_b  = w_boundary && req_if.b_req && (!req_if.a_req || r_last == GR_A);

  always_comb begin
    w_next_buf   = r_buf;
    w_next_owner = r_owner;
    if (w_grant_a) begin
      w_next_buf   = req_if.a_digits;
      w_next_owner = GR_A;
    end else if (w_grant_b) begin
      w_next_buf   = req_if.b_digits;
      w_next_owner = GR_B;
    end
  end

  // Tick is registered, so it is raised when the upcoming cycle is digit 3's final cycle.
  always_comb begin
    if (HAS_GAP)
      w_next_tick = (w_next_idx == 2'd3) && (w_next_phase == PH_GAP) && (w_next_cnt == BLANK_LAST);
    else
      w_next_tick = (w_next_idx == 2'd3) && (w_next_phase == PH_ON) && (w_next_cnt == DWELL_LAST);
  end

  always_ff @(posedge clksys or negedge rst_n) begin
    if (!rst_n) begin
      r_phase <= PH_ON;
      r_cnt   <= '0;
      r_idx   <= 2'd0;
      r_buf   <= 16'h0000;
      r_owner <= GR_A;
      r_last  <= GR_B;
      r_a_ack <= 1'b0;
      r_b_ack <= 1'b0;
      r_tick  <= 1'b0;
      r_ctl   <= 4'b1110;
      r_bcd   <= 4'h0;
    end else begin
      r_phase <= w_next_phase;
      r_cnt   <= w_next_cnt;
      r_idx   <= w_next_idx;
      r_buf   <= w_next_buf;
      r_owner <= w_next_owner;
      if (w_grant_a || w_grant_b)
        r_last <= w_next_owner;
      r_a_ack <= w_grant_a;
      r_b_ack <= w_grant_b;
      r_tick  <= w_next_tick;
      if (w_next_phase == PH_ON) begin
        r_ctl <= ~(4'b0001 << w_next_idx);
        r_bcd <= w_next_buf[{w_next_idx, 2'b00} +: 4];
      end else begin
        r_ctl <= 4'b1111;
        r_bcd <= 4'hF;
      end
    end
  end

  assign req_if.a_ack = r_a_ack;
  assign req_if.b_ack = r_b_ack;
  assign ftsd_ctl     = r_ctl;
  assign ftsd_bcd     = r_bcd;
  assign scan_idx     = r_idx;
  assign owner        = r_owner;
  assign frame_tick   = r_tick;

endmodule

// File: tb/tb_ftsd_scan_sched.sv
// Directed bench for ftsd_scan_sched: a time-based display model plus a grant
// scoreboard (expected winners queued at request time, popped on each ack).
module tb_ftsd_scan_sched;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  ftsd_scan_sched_if ifA ();
  ftsd_scan_sched_if ifZ ();

  logic [3:0] ctlA, bcdA, ctlZ, bcdZ;
  logic [1:0] idxA, idxZ;
  logic       ownerA, ownerZ, tickA, tickZ;

  ftsd_scan_sched #(.DWELL_CYCLES(4), .BLANK_CYCLES(2)) dut (
    .clksys(clk), .rst_n(rst_n), .req_if(ifA),
    .ftsd_ctl(ctlA), .ftsd_bcd(bcdA), .scan_idx(idxA), .owner(ownerA), .frame_tick(tickA)
  );

  ftsd_scan_sched #(.DWELL_CYCLES(3), .BLANK_CYCLES(0)) dutNoGap (
    .clksys(clk), .rst_n(rst_n), .req_if(ifZ),
    .ftsd_ctl(ctlZ), .ftsd_bcd(bcdZ), .scan_idx(idxZ), .owner(ownerZ), .frame_tick(tickZ)
  );

  typedef struct {
    logic        who;
    logic [15:0] digits;
  } grantT;

  grantT       sbq[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  logic [15:0] expBuf = 16'h0000;
  logic        expOwner = 1'b0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic aReq, input logic [15:0] aDig,
                               input logic bReq, input logic [15:0] bDig);
    ifA.a_req    = aReq;
    ifA.a_digits = aDig;
    ifA.b_req    = bReq;
    ifA.b_digits = bDig;
  endtask

  task automatic pushGrant(input logic who, input logic [15:0] digits);
    grantT g;
    g.who    = who;
    g.digits = digits;
    sbq.push_back(g);
  endtask

  // Expected display derived from the cycle count since reset release.
  task automatic checkOutput();
    int t, slot, w, t0;
    logic on, ackA, ackB, ackExp;
    logic [3:0] expCtl, expBcd, expCtl0;
    grantT g;
    t    = cyc % 24;
    slot = t / 6;
    w    = t % 6;
    on   = (w < 4);
    ackA = ifA.a_ack;
    ackB = ifA.b_ack;
    ackExp = (cyc > 0) && (t == 0) && (sbq.size() > 0);
    chk("ack_present", {15'd0, ackA | ackB}, {15'd0, ackExp});
    chk("ack_exclusive", {15'd0, ackA & ackB}, 16'd0);
    if ((ackA | ackB) && sbq.size() > 0) begin
      g = sbq.pop_front();
      chk("ack_who", {15'd0, ackB}, {15'd0, g.who});
      expBuf   = g.digits;
      expOwner = g.who;
    end
    expCtl = 4'b0001 << slot;
    expCtl = on ? ~expCtl : 4'b1111;
    expBcd = on ? expBuf[slot*4 +: 4] : 4'hF;
    chk("ctl", {12'd0, ctlA}, {12'd0, expCtl});
    chk("bcd", {12'd0, bcdA}, {12'd0, expBcd});
    chk("scan_idx", {14'd0, idxA}, slot[15:0]);
    chk("owner", {15'd0, ownerA}, {15'd0, expOwner});
    chk("frame_tick", {15'd0, tickA}, {15'd0, t == 23});

    t0 = cyc % 12;
    expCtl0 = 4'b0001 << (t0 / 3);
    expCtl0 = ~expCtl0;
    chk("nogap_ctl", {12'd0, ctlZ}, {12'd0, expCtl0});
    chk("nogap_bcd", {12'd0, bcdZ}, 16'd0);
    chk("nogap_tick", {15'd0, tickZ}, {15'd0, t0 == 11});
  endtask

  task automatic stepCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
      checkOutput();
    end
  endtask

  // Reset takes effect immediately; release lands just after an edge so the next edge is cycle 1.
  task automatic resetDut();
    rst_n = 1'b0;
    #1;
    chk("rst_ctl", {12'd0, ctlA}, 16'h000E);
    chk("rst_bcd", {12'd0, bcdA}, 16'h0000);
    chk("rst_idx", {14'd0, idxA}, 16'h0000);
    chk("rst_owner", {15'd0, ownerA}, 16'h0000);
    chk("rst_a_ack", {15'd0, ifA.a_ack}, 16'h0000);
    chk("rst_b_ack", {15'd0, ifA.b_ack}, 16'h0000);
    chk("rst_tick", {15'd0, tickA}, 16'h0000);
    chk("rst_nogap_ctl", {12'd0, ctlZ}, 16'h000E);
    repeat (2) @(posedge clk);
    #1;
    rst_n    = 1'b1;
    cyc      = 0;
    expBuf   = 16'h0000;
    expOwner = 1'b0;
    sbq.delete();
    checkOutput();
  endtask

  initial begin
    applyStimulus(1'b0, 16'h0000, 1'b0, 16'h0000);
    ifZ.a_req = 1'b0; ifZ.a_digits = 16'h0000;
    ifZ.b_req = 1'b0; ifZ.b_digits = 16'h0000;
    #2;
    resetDut();

    // Idle scan, then A requests from cycle 5; a short B pulse must never be served.
    stepCycles(5);
    applyStimulus(1'b1, 16'h4321, 1'b0, 16'h0000);
    pushGrant(1'b0, 16'h4321);
    stepCycles(19);
    applyStimulus(1'b0, 16'h4321, 1'b0, 16'h0000);
    stepCycles(6);
    applyStimulus(1'b0, 16'h4321, 1'b1, 16'h9999);
    stepCycles(5);
    applyStimulus(1'b0, 16'h4321, 1'b0, 16'h9999);
    stepCycles(37);

    // Both requesting from reset: round-robin A, B, A.
    applyStimulus(1'b1, 16'h1111, 1'b1, 16'h9876);
    resetDut();
    pushGrant(1'b0, 16'h1111);
    pushGrant(1'b1, 16'h9876);
    pushGrant(1'b0, 16'h1111);
    stepCycles(24);
    ifA.a_req = 1'b0;
    stepCycles(1);
    ifA.a_req = 1'b1;
    stepCycles(23);
    ifA.b_req = 1'b0;
    stepCycles(1);
    ifA.b_req = 1'b1;
    stepCycles(23);
    applyStimulus(1'b0, 16'h1111, 1'b0, 16'h9876);
    stepCycles(4);

    // Reset landing in the ack cycle discards the frame; timing restarts from digit 0.
    applyStimulus(1'b0, 16'h4321, 1'b0, 16'h0000);
    resetDut();
    stepCycles(5);
    applyStimulus(1'b1, 16'h4321, 1'b0, 16'h0000);
    pushGrant(1'b0, 16'h4321);
    stepCycles(19);
    resetDut();
    pushGrant(1'b0, 16'h4321);
    stepCycles(24);
    applyStimulus(1'b0, 16'h4321, 1'b0, 16'h0000);
    stepCycles(24);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
